// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731-style codec configuration sequencer.
package codec_cfg_pkg;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PWR  = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_GAP       = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    // WM8731 7-bit register addresses.
    typedef enum logic [6:0] {
        REG_LLINE  = 7'h00,
        REG_RLINE  = 7'h01,
        REG_LHP    = 7'h02,
        REG_RHP    = 7'h03,
        REG_APATH  = 7'h04,
        REG_DPATH  = 7'h05,
        REG_PDOWN  = 7'h06,
        REG_IFACE  = 7'h07,
        REG_SRATE  = 7'h08,
        REG_ACTIVE = 7'h09,
        REG_RESET  = 7'h0F
    } codec_reg_e;

    // One control word as the codec sees it: {reg[6:0], data[8:0]}.
    function automatic logic [15:0] cfg_word(input codec_reg_e addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Fixed power-up register table; index -> {reg[6:0], data[8:0]}.
module codec_reg_rom
    import codec_cfg_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      word_o
);

    logic [3:0] sel;

    assign sel = 4'(idx_i);

    // Reset first, ACTIVE last; everything in between only matters while inactive.
    always_comb begin
        word_o = cfg_word(REG_ACTIVE, 9'h001);
        case (sel)
            4'd0:    word_o = cfg_word(REG_RESET,  9'h000);
            4'd1:    word_o = cfg_word(REG_LLINE,  9'h017);
            4'd2:    word_o = cfg_word(REG_RLINE,  9'h017);
            4'd3:    word_o = cfg_word(REG_LHP,    9'h179);
            4'd4:    word_o = cfg_word(REG_APATH,  9'h012);
            4'd5:    word_o = cfg_word(REG_DPATH,  9'h000);
            4'd6:    word_o = cfg_word(REG_PDOWN,  9'h000);
            4'd7:    word_o = cfg_word(REG_IFACE,  9'h042);
            4'd8:    word_o = cfg_word(REG_SRATE,  9'h000);
            4'd9:    word_o = cfg_word(REG_ACTIVE, 9'h001);
            default: word_o = cfg_word(REG_ACTIVE, 9'h001);
        endcase
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Power-up configuration sequencer: walks the register ROM and hands each 3-byte
// write to the I2C byte engine, retrying a NACKed entry after an idle gap.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 10,
    parameter logic [6:0]  DEV_ADDR     = DEFAULT_DEV_ADDR,
    parameter int unsigned POWERUP_WAIT = 1000,
    parameter int unsigned GAP_CYCLES   = 64,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        txn_valid,
    input  logic        txn_ready,
    output logic [23:0] txn_data,
    input  logic        txn_done,
    input  logic        txn_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        led,
    output logic [2:0]  dbg_state_o
);

    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WAIT_MAX = (POWERUP_WAIT > GAP_CYCLES) ? POWERUP_WAIT : GAP_CYCLES;
    localparam int unsigned CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int unsigned RTY_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'((POWERUP_WAIT > 0) ? POWERUP_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);
    localparam logic [RTY_W-1:0] RTY_ONE   = RTY_W'(1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic [RTY_W-1:0] retry_q;
    logic             auto_q;
    logic             txn_valid_q;
    logic [23:0]      txn_data_q;
    logic             busy_q, done_q, error_q;
    logic [15:0]      rom_word;
    logic [23:0]      issue_data;
    logic             ack, nack;

    assign ack  = txn_done && !txn_nack;
    assign nack = txn_done &&  txn_nack;

    // ROM is addressed by the next index so a freshly advanced entry can be
    // presented on the same edge that raises txn_valid.
    always_comb begin
        idx_d = idx_q;
        case (state_q)
            S_IDLE:         if (start || auto_q) idx_d = '0;
            S_WAIT_RESP:    if (ack && (idx_q != IDX_LAST)) idx_d = idx_q + IDX_ONE;
            S_DONE, S_FAIL: if (start) idx_d = '0;
            default:        idx_d = idx_q;
        endcase
    end

    codec_reg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx_i  (idx_d),
        .word_o (rom_word)
    );

    assign issue_data = {DEV_ADDR, 1'b0, rom_word};

    // Handshake: txn_valid and txn_data are held stable from the edge that raises
    // txn_valid until an edge samples txn_valid && txn_ready; txn_valid drops on
    // that same edge. The engine answers later with a one-cycle txn_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            auto_q      <= (AUTO_START != 0);
            txn_valid_q <= 1'b0;
            txn_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            idx_q <= idx_d;
            case (state_q)
                S_IDLE: begin
                    if (start || auto_q) begin
                        state_q <= S_WAIT_PWR;
                        auto_q  <= 1'b0;
                        cnt_q   <= '0;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_PWR: begin
                    if (cnt_q == PWR_LAST) begin
                        state_q     <= S_ISSUE;
                        txn_valid_q <= 1'b1;
                        txn_data_q  <= issue_data;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_ISSUE: begin
                    if (txn_ready) begin
                        state_q     <= S_WAIT_RESP;
                        txn_valid_q <= 1'b0;
                    end
                end
                S_WAIT_RESP: begin
                    if (ack) begin
                        retry_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_ISSUE;
                            txn_valid_q <= 1'b1;
                            txn_data_q  <= issue_data;
                        end
                    end else if (nack) begin
                        if (retry_q < RTY_LIMIT) begin
                            state_q <= S_GAP;
                            retry_q <= retry_q + RTY_ONE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_FAIL;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q     <= S_ISSUE;
                        txn_valid_q <= 1'b1;
                        txn_data_q  <= issue_data;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (start) begin
                        state_q <= S_WAIT_PWR;
                        cnt_q   <= '0;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    txn_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign txn_valid   = txn_valid_q;
    assign txn_data    = txn_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign led         = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a small I2C-engine responder.
module tb_codec_cfg_sequencer;

  localparam int NUM_REGS     = 10;
  localparam int POWERUP_WAIT = 16;
  localparam int GAP_CYCLES   = 8;
  localparam int RETRY_MAX    = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        txn_valid;
  logic        txn_ready;
  logic [23:0] txn_data;
  logic        txn_done;
  logic        txn_nack;
  logic        busy;
  logic        done;
  logic        error;
  logic        led;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [23:0] rom_exp [NUM_REGS] = '{
    24'h341E00, 24'h340017, 24'h340217, 24'h340579, 24'h340812,
    24'h340A00, 24'h340C00, 24'h340E42, 24'h341000, 24'h341201
  };
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];

  codec_cfg_sequencer #(
    .NUM_REGS     (NUM_REGS),
    .DEV_ADDR     (7'h1A),
    .POWERUP_WAIT (POWERUP_WAIT),
    .GAP_CYCLES   (GAP_CYCLES),
    .RETRY_MAX    (RETRY_MAX),
    .AUTO_START   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .txn_valid   (txn_valid),
    .txn_ready   (txn_ready),
    .txn_data    (txn_data),
    .txn_done    (txn_done),
    .txn_nack    (txn_nack),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .led         (led),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // accepted-transaction monitor
  always @(posedge clk) begin
    if (reset === 1'b1 && txn_valid === 1'b1 && txn_ready === 1'b1)
      act_q.push_back(txn_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit);
    int waited;
    waited = 0;
    while (txn_valid !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    checks++;
    if (txn_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: txn_valid=%b after %0d cycles, required 1", txn_valid, waited);
    end
  endtask

  // engine responder: accept the pending request, then answer after lat cycles
  task automatic serve(input logic nack_bit, input int lat);
    wait_valid(200);
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    repeat (lat) tick();
    txn_done = 1'b1;
    txn_nack = nack_bit;
    tick();
    txn_done = 1'b0;
    txn_nack = 1'b0;
  endtask

  task automatic compare_queue(input string name);
    logic [23:0] got;
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d transactions, required %0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < act_q.size()) ? act_q[i] : 24'hxxxxxx;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h, required %h", name, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    txn_ready = 1'b0;
    txn_done  = 1'b0;
    txn_nack  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({txn_valid, busy, done, error, led} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/busy/done/error/led=%b, required 00000",
               {txn_valid, busy, done, error, led});
    end
    checks++;
    if (txn_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 000000", txn_data);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
  endtask

  task automatic test_powerup();
    logic early;
    early = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= POWERUP_WAIT; k++) begin
      tick();
      if (txn_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL powerup_early: txn_valid rose before edge %0d, required edge %0d",
               POWERUP_WAIT + 1, POWERUP_WAIT + 1);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL powerup_busy: got %b, required 1", busy);
    end
    tick();
    checks++;
    if (txn_valid !== 1'b1) begin
      errors++;
      $display("FAIL powerup_valid: got %b at edge %0d, required 1", txn_valid, POWERUP_WAIT + 1);
    end
    checks++;
    if (txn_data !== 24'h341E00) begin
      errors++;
      $display("FAIL powerup_data: got %h, required 341e00", txn_data);
    end
    checks++;
    if (dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL powerup_state: got %0d, required 2", dbg_state);
    end
  endtask

  task automatic test_stall();
    logic stable;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (txn_valid !== 1'b1 || txn_data !== 24'h341E00) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL stall_stable: valid=%b data=%h, required 1 and 341e00 throughout", txn_valid, txn_data);
    end
    checks++;
    if (act_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_no_accept: got %0d transactions, required 0", act_q.size());
    end
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    checks++;
    if (act_q.size() !== 1 || txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: count=%0d valid=%b, required 1 and 0", act_q.size(), txn_valid);
    end
    repeat (2) tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    checks++;
    if (txn_valid !== 1'b1 || txn_data !== rom_exp[1]) begin
      errors++;
      $display("FAIL back_to_back: valid=%b data=%h, required 1 and %h", txn_valid, txn_data, rom_exp[1]);
    end
  endtask

  task automatic test_all_ack();
    for (int i = 1; i < NUM_REGS; i++) serve(1'b0, i % 3);
    checks++;
    if ({done, led, busy, error, txn_valid} !== 5'b11000) begin
      errors++;
      $display("FAIL all_ack_flags: done/led/busy/error/valid=%b, required 11000",
               {done, led, busy, error, txn_valid});
    end
    checks++;
    if (dbg_state !== 3'd5) begin
      errors++;
      $display("FAIL all_ack_state: got %0d, required 5", dbg_state);
    end
    repeat (10) tick();
    checks++;
    if (txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_ack_quiet: txn_valid=%b, required 0", txn_valid);
    end
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(rom_exp[i]);
    compare_queue("all_ack");
  endtask

  task automatic test_single_nack();
    logic early;
    act_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || led !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_flags: done=%b led=%b busy=%b, required 0 0 1", done, led, busy);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 3) begin
        serve(1'b1, 1);
        early = 1'b0;
        for (int k = 1; k < GAP_CYCLES; k++) begin
          tick();
          if (txn_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
          errors++;
          $display("FAIL gap_early: txn_valid rose inside the gap, required 0");
        end
        tick();
        checks++;
        if (txn_valid !== 1'b1 || txn_data !== rom_exp[3]) begin
          errors++;
          $display("FAIL gap_reissue: valid=%b data=%h, required 1 and %h", txn_valid, txn_data, rom_exp[3]);
        end
      end
      serve(1'b0, 1);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL single_nack_flags: done=%b error=%b, required 1 0", done, error);
    end
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(rom_exp[i]);
      if (i == 3) exp_q.push_back(rom_exp[3]);
    end
    compare_queue("single_nack");
  endtask

  task automatic test_retry_fail();
    act_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(1'b0, 0);
    serve(1'b0, 0);
    for (int n = 0; n <= RETRY_MAX; n++) serve(1'b1, 2);
    checks++;
    if ({error, busy, done, led} !== 4'b1000) begin
      errors++;
      $display("FAIL fail_flags: error/busy/done/led=%b, required 1000", {error, busy, done, led});
    end
    checks++;
    if (dbg_state !== 3'd6) begin
      errors++;
      $display("FAIL fail_state: got %0d, required 6", dbg_state);
    end
    repeat (100) tick();
    checks++;
    if (txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL fail_quiet: txn_valid=%b, required 0", txn_valid);
    end
    exp_q.delete();
    exp_q.push_back(rom_exp[0]);
    exp_q.push_back(rom_exp[1]);
    repeat (RETRY_MAX + 1) exp_q.push_back(rom_exp[2]);
    compare_queue("retry_fail");
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fail_restart: error=%b busy=%b, required 0 1", error, busy);
    end
    repeat (POWERUP_WAIT - 1) tick();
    checks++;
    if (txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL fail_restart_early: txn_valid=%b one edge early, required 0", txn_valid);
    end
    tick();
    checks++;
    if (txn_valid !== 1'b1 || txn_data !== rom_exp[0]) begin
      errors++;
      $display("FAIL fail_restart_issue: valid=%b data=%h, required 1 and %h", txn_valid, txn_data, rom_exp[0]);
    end
  endtask

  task automatic test_reset_midrun();
    // pending request in ISSUE
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({txn_valid, busy, done, error} !== 4'b0 || txn_data !== 24'h0) begin
      errors++;
      $display("FAIL async_reset_issue: valid/busy/done/error=%b data=%h, required 0000 000000",
               {txn_valid, busy, done, error}, txn_data);
    end
    @(negedge clk);
    reset = 1'b1;
    act_q.delete();
    serve(1'b0, 0);
    wait_valid(10);
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    tick();
    checks++;
    if (dbg_state !== 3'd3) begin
      errors++;
      $display("FAIL midrun_state: got %0d, required 3", dbg_state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({txn_valid, busy, done, error, led} !== 5'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_resp: valid/busy/done/error/led=%b state=%0d, required 00000 0",
               {txn_valid, busy, done, error, led}, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    // a stray txn_done outside WAIT_RESP must be ignored
    tick();
    txn_done = 1'b1;
    txn_nack = 1'b1;
    tick();
    txn_done = 1'b0;
    txn_nack = 1'b0;
    serve(1'b0, 0);
    serve(1'b0, 0);
    exp_q.delete();
    exp_q.push_back(rom_exp[0]);
    exp_q.push_back(rom_exp[1]);
    exp_q.push_back(rom_exp[0]);
    exp_q.push_back(rom_exp[1]);
    compare_queue("reset_restart");
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_stall();
    test_all_ack();
    test_single_nack();
    test_retry_fail();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequences the power-up register configuration of the audio codec (WM8731-style, 7-bit register address + 9-bit data) over a byte-level I2C transaction engine. It walks a fixed register table, hands each 3-byte write to the I2C engine through a valid/ready handshake, and retries on NACK. It reports done/error to the rest of the DSP design. It sits between reset/top-level control and the I2C master that drives `scl`/`sda`.

## Interface
Parameters:
- `NUM_REGS`, 10: number of table entries written per run.
- `DEV_ADDR`, 7'h1A: codec I2C 7-bit address.
- `POWERUP_WAIT`, 1000: clk cycles to wait before the first write.
- `GAP_CYCLES`, 64: idle cycles between a NACK and the re-issue.
- `RETRY_MAX`, 3: retries per entry after the first attempt (4 attempts total).
- `AUTO_START`, 1: when 1, a run begins automatically after reset.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = in reset).
- `start`  in  1: single-cycle pulse; begins a run from IDLE/DONE/FAIL.
- `txn_valid`  out  1: write request to the I2C engine.
- `txn_ready`  in  1: engine accepts the request.
- `txn_data`  out  24: {DEV_ADDR,1'b0, reg[6:0],data[8], data[7:0]}, MSB byte first.
- `txn_done`  in  1: one-cycle pulse, transaction finished.
- `txn_nack`  in  1: valid with `txn_done`; 1 = any byte NACKed.
- `busy`  out  1: run in progress.
- `done`  out  1: sticky, all entries ACKed.
- `error`  out  1: sticky, retries exhausted.
- `led`  out  1: equals `done` (board status LED).

## Operation
- States: IDLE, WAIT_PWR, ISSUE, WAIT_RESP, GAP, DONE, FAIL.
- Reset: state IDLE, all outputs 0, index 0, retry count 0, counters 0.
- IDLE -> WAIT_PWR on `start`, or on the first clock after reset release if `AUTO_START`=1.
- WAIT_PWR: counts `POWERUP_WAIT` cycles, then ISSUE.
- ISSUE:
  - `txn_valid`=1 and `txn_data` = table[index].
  - Both stay stable until `txn_valid`&&`txn_ready` is sampled.
  - On acceptance: WAIT_RESP, with `txn_valid`=0 from the next cycle.
- WAIT_RESP: waits for `txn_done`.
  - ACK with index = NUM_REGS-1 -> DONE.
  - ACK otherwise -> index+1, retry count cleared, ISSUE.
  - NACK with retry count < RETRY_MAX -> retry count+1, GAP.
  - NACK otherwise -> FAIL.
- GAP: counts `GAP_CYCLES` cycles, then ISSUE with the same index.
- DONE: `done`=`led`=1, `busy`=0. `start` clears `done`, resets index, goes to WAIT_PWR.
- FAIL: `error`=1, `busy`=0, no further requests. `start` clears `error`, resets index, goes to WAIT_PWR.
- `busy`=1 in WAIT_PWR, ISSUE, WAIT_RESP and GAP. `start` is ignored while busy.
- `txn_done` outside WAIT_RESP is ignored.
- `txn_done` in the same cycle as acceptance is impossible by engine contract and is not handled.
- Widths:
  - index: `$clog2(NUM_REGS)`.
  - wait counter: `$clog2(max(POWERUP_WAIT,GAP_CYCLES)+1)`.
  - retry count: `$clog2(RETRY_MAX+1)`.
  - Counters saturate at their terminal value and never wrap.

## Timing
- All outputs are registered.
- `txn_valid` rises on rising edge POWERUP_WAIT+1 after the first edge following reset release (AUTO_START=1).
- Back-to-back ACKed entries: `txn_valid` re-asserts on the edge after `txn_done`.
- NACK: `txn_valid` re-asserts GAP_CYCLES+1 edges after `txn_done`.
- `done`/`error` assert on the edge after the final `txn_done`.
- Reset assertion mid-run forces all outputs to 0 immediately (asynchronous), including a pending `txn_valid`.

## Structure
- Package `codec_cfg_pkg`:
  - state enum.
  - WM8731 register address constants (LLINE, RLINE, LHP, RHP, APATH, DPATH, PDOWN, IFACE, SRATE, ACTIVE, RESET).
  - default `DEV_ADDR`.
- Sub-module `codec_reg_rom`:
  - combinational index -> 16-bit {reg,data} table.
  - entry 0 = RESET (16'h1E00); last entry = ACTIVE (16'h1201).

## Test plan
- Reset release, AUTO_START=1, POWERUP_WAIT=16: `txn_valid` rises at edge 17; `txn_data`=24'h341E00; `busy`=1.
- Hold `txn_ready`=0 for 5 cycles: `txn_valid` and `txn_data` stay constant; one transaction is counted after `txn_ready`=1.
- All ACK, NUM_REGS=10: exactly 10 transactions in table order, last 24'h341201; then `done`=`led`=1, `busy`=0, `txn_valid` stays 0.
- Single NACK on index 3: same `txn_data` re-issued GAP_CYCLES+1 edges later; 11 transactions total; `done`=1, `error`=0.
- NACK 4 times on index 2 (RETRY_MAX=3): `error`=1 after the 4th `txn_done`, no 5th request. A `start` pulse clears `error` and re-issues index 0 after POWERUP_WAIT.
- Assert `reset`=0 during WAIT_RESP: `txn_valid`, `busy`, `done`, `error` = 0 without a clock edge. After release, the run restarts from index 0.
